// File: rtl/compress_ctrl_pkg.sv
// Shared types and defaults for the compressor match-pipeline sequencer.
package compress_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int WORD_W           = 64;
  localparam int LINE_WORDS       = 8;
  localparam int MATCH_PIPE_DEPTH = 2;

  // Width of a word index; never narrower than one bit.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/pipe_valid_tracker.sv
// Valid/last shift register that follows issued words down the match pipeline.
module pipe_valid_tracker #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic push_valid_i,
  input  logic push_last_i,
  input  logic clear_i,
  output logic tail_valid_o,
  output logic tail_last_o
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] last_q, last_d;

  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    if (clear_i) begin
      vld_d  = '0;
      last_d = '0;
    end else if (enable_i) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld_d[i]  = vld_q[i-1];
        last_d[i] = last_q[i-1];
      end
      vld_d[0]  = push_valid_i;
      last_d[0] = push_last_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign tail_valid_o = vld_q[DEPTH-1];
  assign tail_last_o  = last_q[DEPTH-1];

endmodule

// File: rtl/compress_pipe_ctrl.sv
// Sequencer for the compressor match pipeline: takes a cache line, clears the
// match dictionary, issues the words in order and tracks them to the encoder.
module compress_pipe_ctrl
  import compress_ctrl_pkg::*;
#(
  parameter int WIDTH      = WORD_W,
  parameter int WORDS      = LINE_WORDS,
  parameter int PIPE_DEPTH = MATCH_PIPE_DEPTH
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_line_valid,
  output logic                    o_line_ready,
  input  logic [WIDTH*WORDS-1:0]  i_line_data,
  input  logic                    i_flush,
  output logic [WIDTH-1:0]        o_word,
  output logic                    o_word_valid,
  output logic [idx_w(WORDS)-1:0] o_word_idx,
  output logic                    o_stage_en,
  output logic                    o_dict_clear,
  output logic                    o_out_valid,
  output logic                    o_last,
  input  logic                    i_out_ready,
  output logic                    o_line_done,
  output logic                    o_busy,
  output state_e                  o_state
);

  localparam int            IW       = idx_w(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [WIDTH*WORDS-1:0] line_q, line_d;
  logic                   issue;
  logic                   tail_valid;
  logic                   tail_last;
  logic                   stage_en;

  // Handshakes: a line moves on i_line_valid & o_line_ready at the clock edge;
  // the tail item moves on o_out_valid & i_out_ready, and a stalled tail
  // freezes the whole match pipeline through stage_en.
  assign issue    = (state_q == ISSUE);
  assign stage_en = ~(tail_valid & ~i_out_ready);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    line_d       = line_q;
    o_line_ready = 1'b0;
    o_dict_clear = 1'b0;
    o_word_valid = 1'b0;
    o_line_done  = 1'b0;
    case (state_q)
      IDLE: begin
        o_line_ready = ~i_flush;
        if (i_line_valid && o_line_ready) begin
          line_d  = i_line_data;
          idx_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        o_dict_clear = 1'b1;
        state_d      = ISSUE;
      end
      ISSUE: begin
        o_word_valid = 1'b1;
        if (stage_en) begin
          if (idx_q == LAST_IDX) state_d = DRAIN;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        o_line_done = tail_valid & tail_last & i_out_ready;
        if (o_line_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush abandons the line; the buffer is left alone since it reloads on accept.
    if (i_flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
    end
  end

  pipe_valid_tracker #(
    .DEPTH(PIPE_DEPTH)
  ) u_tracker (
    .clk_i        (i_clk),
    .reset_i      (i_reset),
    .enable_i     (stage_en),
    .push_valid_i (issue),
    .push_last_i  (issue && (idx_q == LAST_IDX)),
    .clear_i      (i_flush),
    .tail_valid_o (tail_valid),
    .tail_last_o  (tail_last)
  );

  assign o_word      = line_q[idx_q*WIDTH +: WIDTH];
  assign o_word_idx  = idx_q;
  assign o_stage_en  = stage_en;
  assign o_out_valid = tail_valid;
  assign o_last      = tail_last & tail_valid;
  assign o_busy      = (state_q != IDLE);
  assign o_state     = state_q;

endmodule

// File: tb/tb_compress_pipe_ctrl.sv
// Self-checking bench for compress_pipe_ctrl: vector table, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_compress_pipe_ctrl;
  import compress_ctrl_pkg::*;

  localparam int W  = 64;
  localparam int N  = 8;
  localparam int D  = 2;
  localparam int IW = idx_w(N);

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst, line_valid, flush, out_ready;
  logic [W*N-1:0] line_data;
  logic           line_ready, word_valid, stage_en, dict_clear;
  logic           out_valid, last, line_done, busy;
  logic [W-1:0]   word;
  logic [IW-1:0]  word_idx;
  state_e         state_dbg;

  always #5 clk = ~clk;

  compress_pipe_ctrl #(.WIDTH(W), .WORDS(N), .PIPE_DEPTH(D)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_line_valid (line_valid),
    .o_line_ready (line_ready),
    .i_line_data  (line_data),
    .i_flush      (flush),
    .o_word       (word),
    .o_word_valid (word_valid),
    .o_word_idx   (word_idx),
    .o_stage_en   (stage_en),
    .o_dict_clear (dict_clear),
    .o_out_valid  (out_valid),
    .o_last       (last),
    .i_out_ready  (out_ready),
    .o_line_done  (line_done),
    .o_busy       (busy),
    .o_state      (state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // A line is a list of words still to issue (exp_q); issued words travel as
  // items with an age, reaching the encoder side after D enabled cycles.
  bit           m_active, m_clr;
  int           m_issued;
  logic [W-1:0] exp_q[$];
  int           age_q[$];
  bit           lst_q[$];
  bit           e_tail_v, e_tail_l, e_stage, e_ready, e_clr, e_wv, e_done;

  task automatic model_reset();
    m_active = 0; m_clr = 0; m_issued = 0;
    exp_q.delete(); age_q.delete(); lst_q.delete();
  endtask

  task automatic model_eval();
    e_tail_v = 0; e_tail_l = 0;
    foreach (age_q[i]) if (age_q[i] == D) begin e_tail_v = 1; e_tail_l = lst_q[i]; end
    e_stage = !(e_tail_v && !out_ready);
    e_ready = !m_active && !flush;
    e_clr   = m_active && m_clr;
    e_wv    = m_active && !m_clr && (m_issued < N);
    e_done  = m_active && !m_clr && (m_issued == N) && e_tail_v && e_tail_l && out_ready;
  endtask

  task automatic model_check();
    chk("m_ready", line_ready, e_ready);
    chk("m_dict_clear", dict_clear, e_clr);
    chk("m_word_valid", word_valid, e_wv);
    if (e_wv) begin
      chk("m_word", word, exp_q[0]);
      chk("m_word_idx", word_idx, 64'(m_issued));
    end
    chk("m_stage_en", stage_en, e_stage);
    chk("m_out_valid", out_valid, e_tail_v);
    chk("m_last", last, e_tail_v & e_tail_l);
    chk("m_line_done", line_done, e_done);
    chk("m_busy", busy, m_active);
  endtask

  task automatic model_advance();
    if (rst) model_reset();
    else if (flush) model_reset();
    else begin
      if (e_stage) begin
        foreach (age_q[i]) age_q[i]++;
        while (age_q.size() > 0 && age_q[0] > D) begin
          void'(age_q.pop_front());
          void'(lst_q.pop_front());
        end
        if (e_wv) begin
          age_q.push_back(1);
          lst_q.push_back(m_issued == N - 1);
          void'(exp_q.pop_front());
          m_issued++;
        end
      end
      if (e_clr) m_clr = 0;
      if (e_done) m_active = 0;
      if (e_ready && line_valid) begin
        m_active = 1; m_clr = 1; m_issued = 0;
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(line_data[k*W +: W]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    #1;
    model_eval();
    if (chk_en) model_check();
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [W*N-1:0] make_line(input int base);
    logic [W*N-1:0] l;
    l = '0;
    for (int k = 0; k < N; k++) l[k*W +: W] = 64'(base * (k + 1));
    return l;
  endfunction

  task automatic wait_done(input string tag);
    int b;
    bit seen;
    b = 0; seen = 0;
    while (busy && b < 64) begin
      #1;
      if (line_done) seen = 1;
      step();
      b++;
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit lv, ordy;
    int base;
    bit e_ready, e_clr, e_wv, e_stage, e_ov, e_last, e_done;
    int e_idx;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;
    // basic line, words 0x11..0x88, consumer always ready
    for (int c = 0; c < 12; c++) begin
      v.lv = (c == 0); v.ordy = 1; v.base = 'h11;
      v.e_ready = (c == 0); v.e_clr = (c == 1); v.e_wv = (c >= 2 && c <= 9);
      v.e_idx = c - 2; v.e_stage = 1; v.e_ov = (c >= 4 && c <= 11);
      v.e_last = (c == 11); v.e_done = (c == 11);
      tbl.push_back(v);
    end
    // second line with the consumer stalled in cycles 5..7
    for (int c = 0; c < 16; c++) begin
      v.lv = (c == 0); v.ordy = !(c >= 5 && c <= 7); v.base = 'h13;
      v.e_ready = (c == 0 || c == 15); v.e_clr = (c == 1); v.e_wv = (c >= 2 && c <= 12);
      v.e_idx = (c < 5) ? c - 2 : (c <= 8) ? 3 : c - 5;
      v.e_stage = !(c >= 5 && c <= 7); v.e_ov = (c >= 4 && c <= 14);
      v.e_last = (c == 14); v.e_done = (c == 14);
      tbl.push_back(v);
    end

    // reset
    rst = 1; line_valid = 0; flush = 0; out_ready = 1; line_data = '0;
    model_reset();
    step(); step();
    rst = 0; chk_en = 1;
    #1;
    chk("rst_ready", line_ready, 1);
    chk("rst_dict_clear", dict_clear, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_word", word, 0);
    chk("rst_idx", word_idx, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_last", last, 0);
    chk("rst_done", line_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, IDLE);

    // table
    foreach (tbl[r]) begin
      line_valid = tbl[r].lv; out_ready = tbl[r].ordy; flush = 0;
      if (tbl[r].lv) line_data = make_line(tbl[r].base);
      #1;
      chk("tbl_ready", line_ready, tbl[r].e_ready);
      chk("tbl_dict_clear", dict_clear, tbl[r].e_clr);
      chk("tbl_word_valid", word_valid, tbl[r].e_wv);
      if (tbl[r].e_wv) begin
        chk("tbl_word", word, 64'(tbl[r].base * (tbl[r].e_idx + 1)));
        chk("tbl_idx", word_idx, 64'(tbl[r].e_idx));
      end
      chk("tbl_stage_en", stage_en, tbl[r].e_stage);
      chk("tbl_out_valid", out_valid, tbl[r].e_ov);
      chk("tbl_last", last, tbl[r].e_last);
      chk("tbl_done", line_done, tbl[r].e_done);
      step();
    end
    out_ready = 1; line_valid = 0;

    // flush mid-issue, then a fresh line restarts at idx 0
    line_valid = 1; line_data = make_line('h21);
    step(); line_valid = 0;
    step(); step(); step(); step();
    #1; chk("fl_idx3", word_idx, 3);
    flush = 1;
    step(); flush = 0;
    #1;
    chk("fl_busy", busy, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_ready", line_ready, 1);
    chk("fl_done", line_done, 0);
    line_valid = 1; line_data = make_line('h31);
    step(); line_valid = 0;
    #1; chk("fl_dict_clear", dict_clear, 1);
    step();
    #1; chk("fl_idx0", word_idx, 0); chk("fl_word0", word, 64'h31);
    wait_done("fl");

    // flush and a new line in the same idle cycle
    line_valid = 1; flush = 1; line_data = make_line('h41);
    #1; chk("fv_ready0", line_ready, 0);
    step(); flush = 0;
    #1; chk("fv_not_accepted", busy, 0); chk("fv_ready1", line_ready, 1);
    step(); line_valid = 0;
    #1; chk("fv_dict_clear", dict_clear, 1);
    wait_done("fv");

    // reset glitch between edges is ignored; a sampled reset in DRAIN kills the line
    line_valid = 1; line_data = make_line('h51);
    step(); line_valid = 0;
    for (int c = 1; c < 9; c++) step();
    rst = 1; #2; rst = 0;
    step();
    #1;
    chk("rs_busy", busy, 1);
    chk("rs_word_valid", word_valid, 0);
    chk("rs_word_hold", word, 64'h51 * 8);
    chk("rs_out_valid", out_valid, 1);
    rst = 1;
    step(); rst = 0;
    #1;
    chk("rs_ready", line_ready, 1);
    chk("rs_dict_clear", dict_clear, 0);
    chk("rs_word", word, 0);
    chk("rs_idx", word_idx, 0);
    chk("rs_out_valid0", out_valid, 0);
    chk("rs_last", last, 0);
    chk("rs_done", line_done, 0);
    chk("rs_busy0", busy, 0);
    step();
    #1; chk("rs_no_done", line_done, 0);

    // back-to-back lines with line_valid held high
    line_valid = 1; line_data = make_line('h61);
    for (int c = 0; c <= 24; c++) begin
      if (c == 1) line_data = make_line('h71);
      if (c == 13) line_valid = 0;
      #1;
      if (c == 0)  chk("bb_ready0", line_ready, 1);
      if (c == 11) begin chk("bb_done1", line_done, 1); chk("bb_last1", last, 1); end
      if (c == 12) chk("bb_ready12", line_ready, 1);
      if (c == 15) chk("bb_ov15", out_valid, 0);
      if (c == 16) chk("bb_ov16", out_valid, 1);
      if (c == 23) begin chk("bb_done2", line_done, 1); chk("bb_last2", last, 1); end
      if (c == 24) chk("bb_idle", busy, 0);
      step();
    end

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 49) == 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      line_valid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) line_data[k*W +: W] = {$urandom, $urandom};
      step();
    end
    rst = 0; flush = 0; out_ready = 1; line_valid = 0;
    for (int b = 0; b < 64 && busy; b++) step();
    chk("rand_final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
